// File: rtl/fetch_stage.sv
// Fetch front end: owns the fetch PC, queues {instr, pc} pairs and hands them to decode.
// Optional FETCH_BYPASS_EN: presents imem data straight to decode when the queue is empty.
module fetch_stage #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [INSTR_W-1:0]         id_instr,
    output logic [PC_W-1:0]            id_pc,
    output logic [PC_W-1:0]            id_pc_p4,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    pc_q;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];

    logic empty;
    logic bypass;
    logic pop;
    logic pop_q;
    logic push;
    logic advance;

    assign empty = (count == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = empty & ~redirect;
`else
    assign bypass = 1'b0;
`endif

    assign id_valid = (~empty | bypass) & ~redirect;
    assign pop      = id_valid & id_ready;
    // A bypassed word consumed directly never enters the queue.
    assign pop_q    = pop & ~bypass;
    assign push     = ~redirect & ((count < CNT_W'(DEPTH)) | pop_q) & ~(bypass & id_ready);
    assign advance  = push | (bypass & pop);

    assign imem_addr  = pc_q;
    assign id_instr   = bypass ? imem_rdata : mem_instr[rd_ptr];
    assign id_pc      = bypass ? pc_q : mem_pc[rd_ptr];
    assign id_pc_p4   = id_pc + PC_W'(PC_STEP);
    assign fifo_count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= PC_W'(RESET_PC);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (redirect) begin
            pc_q   <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (advance) begin
                pc_q <= pc_q + PC_W'(PC_STEP);
            end
            if (push) begin
                mem_instr[wr_ptr] <= imem_rdata;
                mem_pc[wr_ptr]    <= pc_q;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop_q) begin
                count <= count + CNT_W'(1);
            end else if (pop_q && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the imem model returns a word derived from its address.
// Build with FETCH_BYPASS_EN defined to exercise the zero-latency bypass instead.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [7:0]  id_pc;
    logic [7:0]  id_pc_p4;
    logic [1:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc_p4   (id_pc_p4),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [7:0] a);
        return {8'hC0, a, ~a, 8'h5A};
    endfunction

    assign imem_rdata = f(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here, outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        #1;
        rst      = 1'b0;
        redirect = 1'b0;
        id_ready = ready;
        #1;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        id_ready    = 1'b1;
        #2;
        check("rst_valid",  {31'b0, id_valid}, 32'd0);
        check("rst_instr",  id_instr, 32'd0);
        check("rst_pc",     {24'b0, id_pc}, 32'd0);
        check("rst_pc_p4",  {24'b0, id_pc_p4}, 32'd4);
        check("rst_count",  {30'b0, fifo_count}, 32'd0);
        check("rst_addr",   {24'b0, imem_addr}, 32'd0);

`ifdef FETCH_BYPASS_EN
        do_reset(1'b1);
        check("byp_valid0", {31'b0, id_valid}, 32'd1);
        check("byp_pc0",    {24'b0, id_pc}, 32'h00);
        check("byp_instr0", id_instr, f(8'h00));
        check("byp_cnt0",   {30'b0, fifo_count}, 32'd0);
        tick(); #1;
        check("byp_pc1",    {24'b0, id_pc}, 32'h04);
        check("byp_cnt1",   {30'b0, fifo_count}, 32'd0);
        id_ready = 1'b0;
        tick(); #1;
        check("byp_cnt_a",  {30'b0, fifo_count}, 32'd1);
        check("byp_hold_pc",{24'b0, id_pc}, 32'h04);
        tick(); #1;
        check("byp_cnt_b",  {30'b0, fifo_count}, 32'd2);
        check("byp_head",   id_instr, f(8'h04));
`else
        // Streaming from reset with decode always ready
        do_reset(1'b1);
        check("t1_valid0", {31'b0, id_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            check("t1_valid", {31'b0, id_valid}, 32'd1);
            check("t1_pc",    {24'b0, id_pc}, 32'(4 * i));
            check("t1_instr", id_instr, f(8'(4 * i)));
            check("t1_count", {30'b0, fifo_count}, 32'd1);
        end

        // Backpressure fills the queue and stalls the PC
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) tick();
        #1;
        check("t2_count", {30'b0, fifo_count}, 32'd2);
        check("t2_addr",  {24'b0, imem_addr}, 32'h08);
        check("t2_pc",    {24'b0, id_pc}, 32'h00);
        id_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t2_valid", {31'b0, id_valid}, 32'd1);
            check("t2_order", {24'b0, id_pc}, 32'(4 * i));
            check("t2_instr", id_instr, f(8'(4 * i)));
            tick(); #1;
        end

        // Redirect while full
        do_reset(1'b0);
        tick(); tick(); tick();
        check("t3_full", {30'b0, fifo_count}, 32'd2);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        #1;
        check("t3_kill", {31'b0, id_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("t3_count", {30'b0, fifo_count}, 32'd0);
        check("t3_addr",  {24'b0, imem_addr}, 32'h40);
        check("t3_empty", {31'b0, id_valid}, 32'd0);
        tick(); #1;
        check("t3_valid", {31'b0, id_valid}, 32'd1);
        check("t3_pc",    {24'b0, id_pc}, 32'h40);
        check("t3_instr", id_instr, f(8'h40));

        // Redirect near the top of the address space, PC wraps
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'hF8;
        tick();
        redirect = 1'b0;
        tick(); #1;
        check("t4_pc0", {24'b0, id_pc}, 32'hF8);
        check("t4_p40", {24'b0, id_pc_p4}, 32'hFC);
        tick(); #1;
        check("t4_pc1", {24'b0, id_pc}, 32'hFC);
        check("t4_p41", {24'b0, id_pc_p4}, 32'h00);
        tick(); #1;
        check("t4_pc2", {24'b0, id_pc}, 32'h00);
        check("t4_instr", id_instr, f(8'h00));

        // Asynchronous reset between edges
        tick(); #2;
        rst = 1'b0;
        #1;
        check("t5_valid", {31'b0, id_valid}, 32'd0);
        check("t5_addr",  {24'b0, imem_addr}, 32'h00);
        check("t5_count", {30'b0, fifo_count}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("t5_gap", {31'b0, id_valid}, 32'd0);
        tick(); #1;
        check("t5_pc0", {24'b0, id_pc}, 32'h00);
        tick(); #1;
        check("t5_pc1", {24'b0, id_pc}, 32'h04);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
